// File: rtl/mem_write_m2.sv
`default_nettype none
// ============================================================================
// Module   : mem_write_m2
// Purpose  : Write-side collector for the output-stationary systolic array.
//            Gathers the N result lanes (m2 / valid_m2) of one M x M result
//            matrix and turns each accepted beat into a write on the matching
//            BRAM bank. Bank x owns global rows x*DEPTH .. x*DEPTH+DEPTH-1,
//            the same banked layout used by the m0/m1 readers, so each bank
//            is addressed locally from 0 to DEPTH-1.
//            Per-lane fill counters saturate at DEPTH; a beat arriving on a
//            full lane is dropped and raises a sticky overflow flag.
//
// Ports    : clk                  clock, all state on rising edge
//            rst_n                asynchronous active-low reset
//            start                1-cycle pulse, arms collection of a matrix
//            m2[N]                result lane data (2*D_W bits)
//            valid_m2[N]          per-lane result valid
//            wr_en_bram[N]        per-bank write strobe (registered)
//            wr_addr_bram[N]      per-bank local write address (registered)
//            wr_data_bram[N]      per-bank write data (registered)
//            busy                 high while collecting
//            done                 high once every lane has been filled
//            overflow             sticky: valid seen on an already-full lane
//
// Revision : 1.0  initial release
// ============================================================================
module mem_write_m2 #(
  parameter  int D_W   = 8,
  parameter  int N     = 5,
  parameter  int M     = 5,
  localparam int DEPTH = (M * M) / N,
  // A one-entry bank still needs a 1-bit address port.
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2*D_W-1:0]     m2           [N],
  input  logic [N-1:0]         valid_m2,
  output logic [N-1:0]         wr_en_bram,
  output logic [AW-1:0]        wr_addr_bram [N],
  output logic [2*D_W-1:0]     wr_data_bram [N],
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  // Lane counters are one bit wider than the address so they can hold DEPTH
  // itself, which is the "lane full" marker.
  localparam logic [AW:0] c_depth = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t r_state;
  logic   r_busy;
  logic   r_done;
  logic   r_overflow;

  logic         w_collect;   // accepting beats this cycle
  logic         w_arm;       // start honoured this cycle (IDLE or DONE)
  logic [N-1:0] w_full;      // lane already holds DEPTH entries
  logic [N-1:0] w_fire;      // lane writes at this edge
  logic [N-1:0] w_last;      // lane will be full after this edge
  logic         w_ovf_hit;   // some valid beat hit a full lane

  assign w_collect = (r_state == S_COLLECT);
  assign w_arm     = start && (r_state != S_COLLECT);
  assign w_ovf_hit = w_collect && |(valid_m2 & w_full);

  // --------------------------------------------------------------------------
  // Per-lane write path: fill counter plus registered BRAM write port.
  // --------------------------------------------------------------------------
  for (genvar x = 0; x < N; x++) begin : g_lane
    logic [AW:0]      r_cnt;
    logic             r_en;
    logic [AW-1:0]    r_addr;
    logic [2*D_W-1:0] r_data;

    assign w_full[x] = (r_cnt == c_depth);
    assign w_fire[x] = w_collect && valid_m2[x] && !w_full[x];
    // Looks one edge ahead so done/busy change together with the last strobe.
    assign w_last[x] = ((r_cnt + {{AW{1'b0}}, w_fire[x]}) == c_depth);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt  <= '0;
        r_en   <= 1'b0;
        r_addr <= '0;
        r_data <= '0;
      end else begin
        r_en <= 1'b0;
        if (w_arm) begin
          r_cnt <= '0;
        end else if (w_fire[x]) begin
          // Address and data are held between writes; only the strobe pulses.
          r_en   <= 1'b1;
          r_addr <= r_cnt[AW-1:0];
          r_data <= m2[x];
          r_cnt  <= r_cnt + 1'b1;
        end
      end
    end

    assign wr_en_bram[x]   = r_en;
    assign wr_addr_bram[x] = r_addr;
    assign wr_data_bram[x] = r_data;
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered status outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_COLLECT;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
          end
        end

        S_COLLECT: begin
          // start is deliberately ignored here, even alongside the final beat.
          if (w_ovf_hit) begin
            r_overflow <= 1'b1;
          end
          if (&w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        S_DONE: begin
          if (start) begin
            r_state    <= S_COLLECT;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mem_write_m2.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_write_m2
// Purpose  : Self-checking bench for mem_write_m2 (D_W=8, N=5, M=5, DEPTH=5).
//            A behavioural model tracks how many beats each lane has taken
//            for the current matrix and predicts every output after each
//            clock edge; directed scenarios are followed by a random run.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_write_m2;

  localparam int D_W   = 8;
  localparam int N     = 5;
  localparam int M     = 5;
  localparam int DEPTH = (M * M) / N;
  localparam int AW    = $clog2(DEPTH);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [2*D_W-1:0]   m2 [N];
  logic [N-1:0]       valid_m2 = '0;
  logic [N-1:0]       wr_en_bram;
  logic [AW-1:0]      wr_addr_bram [N];
  logic [2*D_W-1:0]   wr_data_bram [N];
  logic               busy;
  logic               done;
  logic               overflow;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  bit       m_active;        // a matrix is being collected
  bit       m_done;
  bit       m_ovf;
  int       m_taken [N];     // beats accepted per lane for this matrix
  bit [N-1:0] m_en;
  int       m_addr [N];
  int       m_data [N];

  mem_write_m2 #(.D_W(D_W), .N(N), .M(M)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .m2           (m2),
    .valid_m2     (valid_m2),
    .wr_en_bram   (wr_en_bram),
    .wr_addr_bram (wr_addr_bram),
    .wr_data_bram (wr_data_bram),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_done   = 0;
    m_ovf    = 0;
    m_en     = '0;
    for (int x = 0; x < N; x++) begin
      m_taken[x] = 0;
      m_addr[x]  = 0;
      m_data[x]  = 0;
    end
  endtask

  // One clock edge of the model, using the inputs presented before the edge.
  task automatic model_edge();
    int complete;
    m_en = '0;
    if (!m_active) begin
      if (start) begin
        m_active = 1;
        m_done   = 0;
        m_ovf    = 0;
        for (int x = 0; x < N; x++) m_taken[x] = 0;
      end
    end else begin
      complete = 0;
      for (int x = 0; x < N; x++) begin
        if (valid_m2[x]) begin
          if (m_taken[x] < DEPTH) begin
            m_en[x]   = 1'b1;
            m_addr[x] = m_taken[x];
            m_data[x] = int'(m2[x]);
            m_taken[x]++;
          end else begin
            m_ovf = 1;
          end
        end
        if (m_taken[x] == DEPTH) complete++;
      end
      if (complete == N) begin
        m_active = 0;
        m_done   = 1;
      end
    end
  endtask

  task automatic check_all(input string ph);
    check_val({ph, "_wr_en"}, int'(wr_en_bram), int'(m_en));
    check_val({ph, "_busy"}, int'(busy), int'(m_active));
    check_val({ph, "_done"}, int'(done), int'(m_done));
    check_val({ph, "_ovf"}, int'(overflow), int'(m_ovf));
    for (int x = 0; x < N; x++) begin
      check_val($sformatf("%s_addr%0d", ph, x), int'(wr_addr_bram[x]), m_addr[x]);
      check_val($sformatf("%s_data%0d", ph, x), int'(wr_data_bram[x]), m_data[x]);
    end
  endtask

  task automatic set_data(input int k);
    for (int x = 0; x < N; x++) m2[x] = 16'(16 * k + x);
  endtask

  // Called on a falling edge; returns on the next falling edge.
  task automatic cyc(input string ph, input bit st, input logic [N-1:0] v);
    start    = st;
    valid_m2 = v;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all(ph);
    @(negedge clk);
    start    = 1'b0;
    valid_m2 = '0;
  endtask

  // Asserts reset in the middle of the low clock phase.
  task automatic do_reset(input string ph);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(ph);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all({ph, "_rel"});
    @(negedge clk);
  endtask

  initial begin
    int done_at;
    logic [N-1:0] v;
    model_reset();
    set_data(0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: some activity, then asynchronous reset mid-clock
    cyc("t1_arm", 1'b1, '0);
    set_data(3);
    cyc("t1_beat", 1'b0, '1);
    do_reset("t1_rst");

    // 2: full-width burst, data 16*k+x
    cyc("t2_arm", 1'b1, '0);
    for (int k = 0; k < DEPTH; k++) begin
      set_data(k);
      cyc($sformatf("t2_k%0d", k), 1'b0, '1);
      check_val("t2_addr_lane0", int'(wr_addr_bram[0]), k);
      check_val("t2_data_lane4", int'(wr_data_bram[4]), 16 * k + 4);
    end
    check_val("t2_done", int'(done), 1);
    check_val("t2_busy", int'(busy), 0);

    // 3: skewed lanes, lane x starts x cycles after lane 0
    cyc("t3_arm", 1'b1, '0);
    done_at = -1;
    for (int t = 0; t < DEPTH + N - 1; t++) begin
      for (int x = 0; x < N; x++) v[x] = (t >= x) && (t < x + DEPTH);
      set_data(t);
      cyc($sformatf("t3_t%0d", t), 1'b0, v);
      if (done && done_at < 0) done_at = t + 1;
    end
    check_val("t3_done_cycle", done_at, 9);

    // 4: extra beat on full lane 0 while lane 4 is still pending
    cyc("t4_arm", 1'b1, '0);
    for (int k = 0; k < DEPTH; k++) begin
      set_data(k);
      cyc($sformatf("t4_k%0d", k), 1'b0, (k < DEPTH - 2) ? 5'b11111 : 5'b01111);
    end
    set_data(7);
    cyc("t4_ovf", 1'b0, 5'b10001);
    check_val("t4_no_wr0", int'(wr_en_bram[0]), 0);
    check_val("t4_ovf_set", int'(overflow), 1);
    set_data(8);
    cyc("t4_last", 1'b0, 5'b10000);
    cyc("t4_hold", 1'b0, '0);
    check_val("t4_ovf_held", int'(overflow), 1);
    check_val("t4_done_held", int'(done), 1);

    // 5: valids in IDLE ignored, valids in DONE ignored, start in DONE clears
    do_reset("t5_rst");
    set_data(1);
    cyc("t5_idle_v0", 1'b0, '1);
    cyc("t5_idle_v1", 1'b0, '1);
    check_val("t5_idle_nowr", int'(wr_en_bram), 0);
    cyc("t5_arm", 1'b1, '0);
    for (int k = 0; k < DEPTH; k++) begin
      set_data(k + 2);
      cyc($sformatf("t5_k%0d", k), 1'b0, '1);
    end
    set_data(9);
    cyc("t5_done_v", 1'b0, '1);
    cyc("t5_rearm", 1'b1, '1);
    set_data(10);
    cyc("t5_first", 1'b0, '1);
    check_val("t5_addr0", int'(wr_addr_bram[2]), 0);
    check_val("t5_ovf_clr", int'(overflow), 0);

    // 6: reset after two writes per lane, restart from address 0
    set_data(11);
    cyc("t6_second", 1'b0, '1);
    do_reset("t6_rst");
    cyc("t6_arm", 1'b1, '0);
    for (int k = 0; k < DEPTH; k++) begin
      set_data(k + 20);
      cyc($sformatf("t6_k%0d", k), 1'b0, '1);
      if (k == 0) check_val("t6_addr_restart", int'(wr_addr_bram[1]), 0);
    end
    check_val("t6_done", int'(done), 1);

    // 7: random traffic with occasional starts and resets
    for (int i = 0; i < 600; i++) begin
      for (int x = 0; x < N; x++) m2[x] = 16'($urandom);
      if ($urandom_range(0, 199) == 0) do_reset("rnd_rst");
      cyc("rnd", ($urandom_range(0, 9) == 0), N'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
